datamemory_lsu: RTL and testbench

// - Parametrised successor to the word-only data memory: owns the byte-lane array and the RV32I load/store unit.
// - Supports LB/LH/LW/LBU/LHU and SB/SH/SW with sign/zero extension.
// - Adds a req/ready/rsp_valid handshake with a programmable read latency so the core stalls on memory.
// - Sits between the EX/MEM ALU address and the MEM/WB writeback mux.

---
 rtl/dm_pkg.sv | 37 +++
 rtl/dm_load_extract.sv | 43 ++++
 rtl/datamemory_lsu.sv | 183 ++++++++++++++++++
 tb/tb_datamemory_lsu.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/dm_pkg.sv
// Shared types for the data memory / RV32I load-store unit.
//   funct3_t   : RV32I load/store width encodings (instr[14:12])
//   dm_state_t : request FSM states
//   NBYTES     : byte lanes per word
//   f3_illegal : true when funct3 is not a legal load/store width
package dm_pkg;

   localparam int DM_DATA_W = 32;
   localparam int NBYTES    = DM_DATA_W / 8;

   typedef enum logic [2:0] {
      F3_B  = 3'b000,
      F3_H  = 3'b001,
      F3_W  = 3'b010,
      F3_BU = 3'b100,
      F3_HU = 3'b101
   } funct3_t;

   typedef enum logic [1:0] {
      IDLE,
      WAIT,
      RESP
   } dm_state_t;

   // Loads accept B/H/W/BU/HU; stores accept only B/H/W.
   function automatic logic f3_illegal(input logic is_load, input logic [2:0] f3);
      logic bad;
      bad = 1'b1;
      case (f3)
         F3_B, F3_H, F3_W: bad = 1'b0;
         F3_BU, F3_HU:     bad = !is_load;
         default:          bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dm_load_extract.sv
// Combinational load lane select with sign/zero extension.
//   word   in  32  full word read from the array
//   lane   in  2   byte address a[1:0]
//   funct3 in  3   load width/sign encoding
//   rd     out 32  extended load data (0 for non-load encodings)
module dm_load_extract
   import dm_pkg::*;
(
   input  logic [31:0] word,
   input  logic [1:0]  lane,
   input  logic [2:0]  funct3,
   output logic [31:0] rd
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   always_comb begin
      byte_sel = '0;
      case (lane)
         2'd0: byte_sel = word[7:0];
         2'd1: byte_sel = word[15:8];
         2'd2: byte_sel = word[23:16];
         2'd3: byte_sel = word[31:24];
         default: byte_sel = '0;
      endcase
      // Halfword lane ignores a[0]; misalignment is policed in the top.
      half_sel = lane[1] ? word[31:16] : word[15:0];
   end

   always_comb begin
      rd = '0;
      case (funct3)
         F3_B:    rd = {{24{byte_sel[7]}}, byte_sel};
         F3_BU:   rd = {24'h0, byte_sel};
         F3_H:    rd = {{16{half_sel[15]}}, half_sel};
         F3_HU:   rd = {16'h0, half_sel};
         F3_W:    rd = word;
         default: rd = '0;
      endcase
   end

endmodule

// File: rtl/datamemory_lsu.sv
// Byte-lane data memory with RV32I load/store unit and req/ready/rsp_valid
// handshake with programmable read latency.
//   clk       in   rising-edge clock; array written on rising edge
//   reset     in   async active-high reset (array contents not reset)
//   MemRead   in   load request
//   MemWrite  in   store request (ignored when MemRead also high)
//   a         in   byte address
//   wd        in   store data (low bytes used for SB/SH)
//   Funct3    in   instr[14:12]
//   req_ready out  idle and able to accept
//   rsp_valid out  one-cycle response pulse qualifying rd/err
//   rd        out  extended load data
//   err       out  illegal funct3 (or misalignment, see below)
// Optional macro DM_MISALIGN_TRAP_EN: flag misaligned H/HU/W accesses with
// err=1, rd=0 and no array write.
module datamemory_lsu
   import dm_pkg::*;
#(
   parameter int DM_ADDRESS = 9,
   parameter int DATA_W     = 32,
   parameter int RD_LAT     = 1
)(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  MemRead,
   input  logic                  MemWrite,
   input  logic [DM_ADDRESS-1:0] a,
   input  logic [DATA_W-1:0]     wd,
   input  logic [2:0]            Funct3,
   output logic                  req_ready,
   output logic                  rsp_valid,
   output logic [DATA_W-1:0]     rd,
   output logic                  err
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("datamemory_lsu: DATA_W must be 32");
   end
   if (RD_LAT < 1 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("datamemory_lsu: RD_LAT must be in 1..4");
   end

   localparam int         DEPTH = 2 ** (DM_ADDRESS - 2);
   localparam logic [1:0] LAST  = 2'((RD_LAT > 1) ? (RD_LAT - 2) : 0);

   logic [NBYTES-1:0][7:0] mem [DEPTH];

   dm_state_t              state, state_nxt;
   logic [1:0]             lat_cnt, lat_cnt_nxt;
   logic [DM_ADDRESS-1:0]  a_q;
   logic [2:0]             f3_q;

   // Operand set used on the edge where the response is captured: live
   // inputs on the accept edge, the latched request on the last WAIT edge.
   logic                   cap;
   logic                   cap_load;
   logic [DM_ADDRESS-1:0]  cap_a;
   logic [2:0]             cap_f3;
   logic                   cap_err;
   logic                   misalign;
   logic [31:0]            ld_data;
   logic [31:0]            rword;

   logic                   we;
   logic [NBYTES-1:0]      be;
   logic [NBYTES-1:0][7:0] wdat;

   always_comb begin
      state_nxt   = state;
      lat_cnt_nxt = lat_cnt;
      req_ready   = 1'b0;
      rsp_valid   = 1'b0;
      cap         = 1'b0;
      cap_load    = MemRead;
      cap_a       = a;
      cap_f3      = Funct3;
      case (state)
         IDLE: begin
            req_ready = 1'b1;
            if (MemRead || MemWrite) begin
               lat_cnt_nxt = '0;
               if (MemRead && RD_LAT > 1) begin
                  state_nxt = WAIT;
               end else begin
                  state_nxt = RESP;
                  cap       = 1'b1;
               end
            end
         end
         WAIT: begin
            // Only loads ever pass through WAIT.
            cap_load = 1'b1;
            cap_a    = a_q;
            cap_f3   = f3_q;
            if (lat_cnt == LAST) begin
               state_nxt = RESP;
               cap       = 1'b1;
            end else begin
               lat_cnt_nxt = lat_cnt + 2'd1;
            end
         end
         RESP: begin
            rsp_valid = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

`ifdef DM_MISALIGN_TRAP_EN
   always_comb begin
      misalign = 1'b0;
      case (cap_f3)
         F3_H, F3_HU: misalign = cap_a[0];
         F3_W:        misalign = |cap_a[1:0];
         default:     misalign = 1'b0;
      endcase
   end
`else
   assign misalign = 1'b0;
`endif

   assign cap_err = f3_illegal(cap_load, cap_f3) | misalign;
   assign rword   = mem[cap_a[DM_ADDRESS-1:2]];

   dm_load_extract u_extract (
      .word   (rword),
      .lane   (cap_a[1:0]),
      .funct3 (cap_f3),
      .rd     (ld_data)
   );

   always_comb begin
      be   = '0;
      wdat = wd;
      case (Funct3)
         F3_B: begin
            be   = 4'b0001 << a[1:0];
            wdat = {4{wd[7:0]}};
         end
         F3_H: begin
            be   = 4'b0011 << {a[1], 1'b0};
            wdat = {2{wd[15:0]}};
         end
         F3_W: be = 4'b1111;
         default: be = '0;
      endcase
   end

   // A store commits on its accept edge; read priority and errors suppress it.
   assign we = (state == IDLE) && MemWrite && !MemRead && !cap_err && !reset;

   always_ff @(posedge clk) begin
      if (we) begin
         for (int unsigned i = 0; i < NBYTES; i++) begin
            if (be[i]) mem[a[DM_ADDRESS-1:2]][i] <= wdat[i];
         end
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state   <= IDLE;
         lat_cnt <= '0;
         a_q     <= '0;
         f3_q    <= '0;
         rd      <= '0;
         err     <= 1'b0;
      end else begin
         state   <= state_nxt;
         lat_cnt <= lat_cnt_nxt;
         if (state == IDLE) begin
            a_q  <= a;
            f3_q <= Funct3;
         end
         if (cap) begin
            err <= cap_err;
            rd  <= (cap_load && !cap_err) ? ld_data : '0;
         end
      end
   end

endmodule

// File: tb/tb_datamemory_lsu.sv
module tb_datamemory_lsu;
   import dm_pkg::*;

   localparam int LAT = 3;

   logic        clk = 1'b0;
   logic        reset;
   logic        MemRead, MemWrite;
   logic [8:0]  a;
   logic [31:0] wd;
   logic [2:0]  Funct3;
   logic        req_ready, rsp_valid, err;
   logic [31:0] rd;

   int vectors    = 0;
   int miscompares = 0;

   datamemory_lsu #(.DM_ADDRESS(9), .DATA_W(32), .RD_LAT(LAT)) dut (
      .clk(clk), .reset(reset), .MemRead(MemRead), .MemWrite(MemWrite),
      .a(a), .wd(wd), .Funct3(Funct3), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rd(rd), .err(err)
   );

   always #5 clk = ~clk;

   // Drives one request and waits (bounded) for its response.
   // lat = negedges after the accept edge at which rsp_valid is seen; 0 = timeout.
   task automatic issue(input logic r, input logic w, input logic [8:0] addr,
                        input logic [31:0] d, input logic [2:0] f3,
                        output logic rdy0, output int lat, output logic rdy_resp,
                        output logic [31:0] rdv, output logic errv);
      @(negedge clk);
      rdy0 = req_ready;
      MemRead = r; MemWrite = w; a = addr; wd = d; Funct3 = f3;
      @(posedge clk); #1;
      MemRead = 1'b0; MemWrite = 1'b0;
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clk);
         if (rsp_valid) begin lat = k; break; end
      end
      rdy_resp = req_ready; rdv = rd; errv = err;
   endtask

   logic rdy0, rdyr, ev;
   logic [31:0] rv;
   int lat;

   task automatic test_reset;
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_ready got %b exp 1", req_ready); end
      vectors++; if (rsp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_valid got %b exp 0", rsp_valid); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rst_rd got %h exp 0", rd); end
      vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL rst_err got %b exp 0", err); end
   endtask

   task automatic test_word;
      issue(1'b0, 1'b1, 9'h010, 32'hDEADBEEF, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL sw_ready got %b exp 1", rdy0); end
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sw_lat got %0d exp 1", lat); end
      vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL sw_err got %b exp 0", ev); end
      issue(1'b1, 1'b0, 9'h010, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL lw_lat got %0d exp %0d", lat, LAT); end
      vectors++; if (rv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL lw_rd got %h exp deadbeef", rv); end
      vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL lw_err got %b exp 0", ev); end
   endtask

   task automatic test_byte;
      issue(1'b0, 1'b1, 9'h020, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      issue(1'b0, 1'b1, 9'h021, 32'h000000AA, F3_B, rdy0, lat, rdyr, rv, ev);
      vectors++; if (lat !== 1) begin miscompares++; $display("FAIL sb_lat got %0d exp 1", lat); end
      issue(1'b1, 1'b0, 9'h020, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'h0000AA00) begin miscompares++; $display("FAIL sb_lw got %h exp 0000aa00", rv); end
      issue(1'b1, 1'b0, 9'h021, 32'h0, F3_B, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'hFFFFFFAA) begin miscompares++; $display("FAIL lb got %h exp ffffffaa", rv); end
      issue(1'b1, 1'b0, 9'h021, 32'h0, F3_BU, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'h000000AA) begin miscompares++; $display("FAIL lbu got %h exp 000000aa", rv); end
   endtask

   task automatic test_half;
      issue(1'b0, 1'b1, 9'h030, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      issue(1'b0, 1'b1, 9'h032, 32'h00008001, F3_H, rdy0, lat, rdyr, rv, ev);
      issue(1'b1, 1'b0, 9'h032, 32'h0, F3_H, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'hFFFF8001) begin miscompares++; $display("FAIL lh got %h exp ffff8001", rv); end
      issue(1'b1, 1'b0, 9'h032, 32'h0, F3_HU, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'h00008001) begin miscompares++; $display("FAIL lhu got %h exp 00008001", rv); end
      issue(1'b1, 1'b0, 9'h030, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'h80010000) begin miscompares++; $display("FAIL sh_lw got %h exp 80010000", rv); end
   endtask

   task automatic test_misalign;
      logic        exp_err;
      logic [31:0] exp_word;
`ifdef DM_MISALIGN_TRAP_EN
      exp_err = 1'b1; exp_word = 32'h11111111;
`else
      exp_err = 1'b0; exp_word = 32'h22222222;
`endif
      issue(1'b0, 1'b1, 9'h040, 32'h11111111, F3_W, rdy0, lat, rdyr, rv, ev);
      issue(1'b0, 1'b1, 9'h041, 32'h22222222, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (ev !== exp_err) begin miscompares++; $display("FAIL mis_sw_err got %b exp %b", ev, exp_err); end
      issue(1'b1, 1'b0, 9'h040, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== exp_word) begin miscompares++; $display("FAIL mis_word got %h exp %h", rv, exp_word); end
      issue(1'b1, 1'b0, 9'h043, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (ev !== exp_err) begin miscompares++; $display("FAIL mis_lw_err got %b exp %b", ev, exp_err); end
      vectors++; if (rv !== (exp_err ? 32'h0 : exp_word)) begin miscompares++; $display("FAIL mis_lw_rd got %h exp %h", rv, exp_err ? 32'h0 : exp_word); end
   endtask

   task automatic test_reset_mid;
      logic seen;
      seen = 1'b0;
      @(negedge clk);
      MemRead = 1'b1; MemWrite = 1'b0; a = 9'h010; Funct3 = F3_W;
      @(posedge clk); #1;
      MemRead = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      repeat (2) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      reset = 1'b0;
      repeat (5) begin @(negedge clk); if (rsp_valid) seen = 1'b1; end
      vectors++; if (seen !== 1'b0) begin miscompares++; $display("FAIL rmid_valid got %b exp 0", seen); end
      vectors++; if (req_ready !== 1'b1) begin miscompares++; $display("FAIL rmid_ready got %b exp 1", req_ready); end
      vectors++; if (rd !== 32'h0) begin miscompares++; $display("FAIL rmid_rd got %h exp 0", rd); end
      issue(1'b1, 1'b0, 9'h010, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL rmid_keep got %h exp deadbeef", rv); end
   endtask

   task automatic test_both;
      issue(1'b1, 1'b1, 9'h010, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL both_lat got %0d exp %0d", lat, LAT); end
      vectors++; if (rv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL both_rd got %h exp deadbeef", rv); end
      vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL both_err got %b exp 0", ev); end
      issue(1'b1, 1'b0, 9'h010, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL both_mem got %h exp deadbeef", rv); end
   endtask

   task automatic test_illegal;
      issue(1'b1, 1'b0, 9'h010, 32'h0, 3'b111, rdy0, lat, rdyr, rv, ev);
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL ill_ld_lat got %0d exp %0d", lat, LAT); end
      vectors++; if (ev !== 1'b1) begin miscompares++; $display("FAIL ill_ld_err got %b exp 1", ev); end
      vectors++; if (rv !== 32'h0) begin miscompares++; $display("FAIL ill_ld_rd got %h exp 0", rv); end
      issue(1'b0, 1'b1, 9'h010, 32'h0, 3'b011, rdy0, lat, rdyr, rv, ev);
      vectors++; if (ev !== 1'b1) begin miscompares++; $display("FAIL ill_st_err got %b exp 1", ev); end
      issue(1'b1, 1'b0, 9'h010, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rv !== 32'hDEADBEEF) begin miscompares++; $display("FAIL ill_st_mem got %h exp deadbeef", rv); end
      vectors++; if (ev !== 1'b0) begin miscompares++; $display("FAIL ill_clr_err got %b exp 0", ev); end
   endtask

   task automatic test_back_to_back;
      issue(1'b1, 1'b0, 9'h020, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rdyr !== 1'b0) begin miscompares++; $display("FAIL b2b_resp_ready1 got %b exp 0", rdyr); end
      vectors++; if (rv !== 32'h0000AA00) begin miscompares++; $display("FAIL b2b_rd1 got %h exp 0000aa00", rv); end
      issue(1'b1, 1'b0, 9'h030, 32'h0, F3_W, rdy0, lat, rdyr, rv, ev);
      vectors++; if (rdy0 !== 1'b1) begin miscompares++; $display("FAIL b2b_ready2 got %b exp 1", rdy0); end
      vectors++; if (lat !== LAT) begin miscompares++; $display("FAIL b2b_lat2 got %0d exp %0d", lat, LAT); end
      vectors++; if (rdyr !== 1'b0) begin miscompares++; $display("FAIL b2b_resp_ready2 got %b exp 0", rdyr); end
      vectors++; if (rv !== 32'h80010000) begin miscompares++; $display("FAIL b2b_rd2 got %h exp 80010000", rv); end
   endtask

   initial begin
      reset = 1'b1; MemRead = 1'b0; MemWrite = 1'b0;
      a = '0; wd = '0; Funct3 = '0;
      repeat (2) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      test_reset;
      test_word;
      test_byte;
      test_half;
      test_misalign;
      test_reset_mid;
      test_both;
      test_illegal;
      test_back_to_back;
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
